// File: rtl/modexp_par.sv
`default_nettype none
// ============================================================================
// modexp_par : result = a^b mod m, two bit-serial interleaved multipliers run
//              the multiply (acc*base) and square (base*base) steps together.
// Rev 1.0
// ============================================================================
module modexp_par #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int              CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   c_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_REDUCE = 3'd2,
    S_STEP   = 3'd3,
    S_MUL    = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a, r_b, r_m;
  logic [WIDTH-1:0] r_acc, r_base, r_e;
  logic [WIDTH-1:0] r_ra, r_xa, r_ya;
  logic [WIDTH-1:0] r_rb, r_xb, r_yb;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] w_a_step, w_b_step;

  // One MSB-first interleaved step; both operands stay below md, so a single
  // conditional subtract per addition keeps the WIDTH+1-bit sum reduced.
  function automatic logic [WIDTH-1:0] mm_step(
    input logic [WIDTH-1:0] r,
    input logic             xbit,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] md
  );
    logic [WIDTH:0] d;
    logic [WIDTH:0] s;
    d = {r, 1'b0};
    if (d >= {1'b0, md}) d = d - {1'b0, md};
    s = d + (xbit ? {1'b0, y} : {(WIDTH+1){1'b0}});
    if (s >= {1'b0, md}) s = s - {1'b0, md};
    return s[WIDTH-1:0];
  endfunction

  assign w_last   = (r_cnt == c_LAST);
  assign w_a_step = mm_step(r_ra, r_xa[WIDTH-1], r_ya, r_m);
  assign w_b_step = mm_step(r_rb, r_xb[WIDTH-1], r_yb, r_m);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = (r_m <= c_ONE || r_b == '0) ? S_FINISH : S_REDUCE;
      S_REDUCE: if (w_last) w_next = S_STEP;
      S_STEP:   w_next = (r_e == '0) ? S_FINISH : S_MUL;
      S_MUL:    if (w_last) w_next = S_STEP;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      r_base <= '0;
      r_e    <= '0;
      r_ra   <= '0;
      r_xa   <= '0;
      r_ya   <= '0;
      r_rb   <= '0;
      r_xb   <= '0;
      r_yb   <= '0;
      r_cnt  <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a  <= a;
            r_b  <= b;
            r_m  <= m;
            done <= 1'b0;
            busy <= 1'b1;
            err  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        // Degenerate cases park their answer in acc so FINISH is uniform.
        S_LOAD: begin
          if (r_m == '0) begin
            r_acc <= '0;
            err   <= 1'b1;
          end else if (r_m == c_ONE) begin
            r_acc <= '0;
          end else if (r_b == '0) begin
            r_acc <= c_ONE;
          end else begin
            r_acc <= c_ONE;
            r_e   <= r_b;
            r_ra  <= '0;
            r_xa  <= r_a;
            r_ya  <= c_ONE;
            r_cnt <= '0;
          end
        end
        S_REDUCE: begin
          r_ra  <= w_a_step;
          r_xa  <= {r_xa[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_base <= w_a_step;
        end
        S_STEP: begin
          if (r_e != '0) begin
            r_ra  <= '0;
            r_xa  <= r_acc;
            r_ya  <= r_base;
            r_rb  <= '0;
            r_xb  <= r_base;
            r_yb  <= r_base;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          r_ra  <= w_a_step;
          r_xa  <= {r_xa[WIDTH-2:0], 1'b0};
          r_rb  <= w_b_step;
          r_xb  <= {r_xb[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            if (r_e[0]) r_acc <= w_a_step;
            r_base <= w_b_step;
            r_e    <= r_e >> 1;
          end
        end
        S_FINISH: begin
          result <= r_acc;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modexp_par.sv
`default_nettype none
// ============================================================================
// tb_modexp_par : directed/scoreboard bench for modexp_par at WIDTH 8 and 32.
// Rev 1.0
// ============================================================================
module tb_modexp_par;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic [7:0]  a8, b8, m8, res8;
  logic [31:0] a32, b32, m32, res32;
  logic        done8, busy8, err8, done32, busy32, err32;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned res;
    logic            err;
    int              lat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  modexp_par #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst), .start(start8), .a(a8), .b(b8), .m(m8),
    .result(res8), .done(done8), .busy(busy8), .err(err8)
  );

  modexp_par #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst), .start(start32), .a(a32), .b(b32), .m(m32),
    .result(res32), .done(done32), .busy(busy32), .err(err32)
  );

  function automatic longint unsigned mexp(input longint unsigned av,
                                           input longint unsigned bv,
                                           input longint unsigned mv);
    longint unsigned r, bs, e;
    if (mv <= 1) return 0;
    r  = 1;
    bs = av % mv;
    e  = bv;
    while (e != 0) begin
      if (e[0]) r = (r * bs) % mv;
      bs = (bs * bs) % mv;
      e  = e >> 1;
    end
    return r;
  endfunction

  function automatic int lat(input int w, input longint unsigned bv,
                             input longint unsigned mv);
    int l;
    longint unsigned e;
    if (mv <= 1 || bv == 0) return 3;
    l = 0;
    e = bv;
    while (e != 0) begin
      l++;
      e = e >> 1;
    end
    return w + l * (w + 1) + 4;
  endfunction

  task automatic check(input string tag, input longint unsigned obs,
                       input longint unsigned expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] mv, input logic st);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; m8 = mv[7:0]; start8 = st;
    end else begin
      a32 = av; b32 = bv; m32 = mv; start32 = st;
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction

  function automatic logic get_err(input int w);
    return (w == 8) ? err8 : err32;
  endfunction

  function automatic longint unsigned get_res(input int w);
    return (w == 8) ? {56'd0, res8} : {32'd0, res32};
  endfunction

  // Drives start for one edge, then scrambles the operand inputs.
  task automatic launch(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] mv);
    @(negedge clk);
    drive(w, av, bv, mv, 1'b1);
    @(posedge clk);
    #1;
    drive(w, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h3, 1'b0);
    check("accept_busy", get_busy(w), 1);
    check("accept_done", get_done(w), 0);
    check("accept_err",  get_err(w), 0);
  endtask

  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] mv, input int glitch_at);
    exp_t e;
    int   n;
    logic got, busy_ok;
    e.res = mexp(av, bv, mv);
    e.err = (mv == 0);
    e.lat = lat(w, bv, mv);
    q.push_back(e);
    launch(w, av, bv, mv);
    n = 1; got = 1'b0; busy_ok = 1'b1;
    while (n < 5000) begin
      if (get_done(w)) begin
        got = 1'b1;
        break;
      end
      if (!get_busy(w)) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (glitch_at > 0 && n == glitch_at)          drive(w, 32'd1, 32'd1, 32'd3, 1'b1);
      else if (glitch_at > 0 && n == glitch_at + 1) drive(w, 32'd1, 32'd1, 32'd3, 1'b0);
    end
    check("done_timeout", got, 1);
    e = q.pop_front();
    check("result",  get_res(w), e.res);
    check("err",     get_err(w), e.err);
    check("latency", n, e.lat);
    check("busy_throughout", busy_ok, 1);
    check("busy_low_at_done", get_busy(w), 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(8, 0, 0, 0, 1'b0);
    drive(32, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_res8",  get_res(8), 0);
    check("rst_done8", done8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_err8",  err8, 0);
    check("rst_done32", done32, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done8",  done8, 1);
    check("idle_done32", done32, 1);

    run_op(8, 3, 5, 7, 0);
    run_op(8, 10, 3, 7, 0);
    run_op(8, 4, 0, 9, 0);
    run_op(8, 4, 3, 1, 0);
    run_op(8, 4, 3, 0, 0);
    run_op(8, 5, 3, 11, 0);
    run_op(8, 255, 255, 255, 0);
    for (int i = 0; i < 4; i++)
      run_op(8, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(2, 255), 0);

    run_op(32, 2, 10, 1000, 0);
    run_op(32, 32'hFFFFFFFF, 2, 32'hFFFFFFFB, 0);
    run_op(32, 32'h12345678, 32'h0000FFFF, 32'hFFFFFFF1, 0);

    // Start pulsed mid-computation must be ignored.
    run_op(8, 3, 5, 7, 12);

    // Reset while in MUL aborts everything.
    launch(8, 3, 5, 7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_res",  get_res(8), 0);
    check("midrst_done", done8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_err",  err8, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_idle_done", done8, 1);
    run_op(8, 3, 5, 7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
